// File: rtl/single_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : single_cycle_pkg
// Description : Shared definitions for the single-cycle LEGv8 core: opcode
//               constants, ALU operation enum, decoded control bundle,
//               instruction encoders and the fixed instruction ROM image.
// Revision    : 1.0 - initial release
// ============================================================================
package single_cycle_pkg;

  // Opcode fields as they appear in instr[31:21] (or the leading bits thereof)
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg2loc;     // second read port addresses Rt (instr[4:0]) instead of Rm
    logic    alu_src;     // ALU B operand is sign-extended imm9
    logic    mem_to_reg;  // write-back data comes from data RAM
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;      // conditional branch taken when operand is zero
    logic    branch_nz;   // conditional branch taken when operand is nonzero
    logic    uncond;      // unconditional branch
    logic    movz;        // ALU B operand is the shifted MOVZ halfword
    alu_op_e alu_op;
  } ctrl_t;

  // Instruction encoders used to build the ROM image legibly
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm9,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_iw(input logic [1:0] hw, input logic [15:0] imm16,
                                         input logic [4:0] rd);
    return {OP_MOVZ, hw, imm16, rd};
  endfunction

  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm19,
                                         input logic [4:0] rt);
    return {op, imm19, rt};
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] imm26);
    return {OP_B, imm26};
  endfunction

  // Fixed program image; unlisted words are zero, which decodes as a NOP.
  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    logic [31:0] w;
    w = 32'h0;
    case (idx)
      // Program 1: derive 0xF from the initial RAM words
      6'd0:  w = enc_d(OP_LDUR, 9'd0,  5'd31, 5'd9);    // X9  = 1
      6'd1:  w = enc_d(OP_LDUR, 9'd8,  5'd31, 5'd10);   // X10 = 0xA
      6'd2:  w = enc_d(OP_LDUR, 9'd16, 5'd31, 5'd11);   // X11 = 0x5
      6'd3:  w = enc_d(OP_LDUR, 9'd24, 5'd31, 5'd12);   // X12 = 0x0ffbea7deadbeef
      6'd4:  w = enc_r(OP_ORR, 5'd11, 5'd10, 5'd13);    // X13 = 0xF
      6'd5:  w = enc_r(OP_AND, 5'd13, 5'd12, 5'd14);    // X14 = 0xF
      6'd6:  w = enc_r(OP_SUB, 5'd9,  5'd14, 5'd15);    // X15 = 0xE
      6'd7:  w = enc_r(OP_ADD, 5'd9,  5'd15, 5'd15);    // X15 = 0xF
      6'd8:  w = enc_cb(OP_CBZ, 19'd2, 5'd31);          // always taken -> 0x28
      6'd9:  w = enc_r(OP_ADD, 5'd15, 5'd15, 5'd15);    // skipped
      6'd10: w = enc_cb(OP_CBZ, 19'h7fff6, 5'd9);       // X9 != 0, falls through
      6'd11: w = enc_d(OP_STUR, 9'd32, 5'd31, 5'd15);   // RAM[4] = 0xF
      6'd12: w = enc_b(26'd1);                          // -> 0x34
      6'd13: w = enc_d(OP_LDUR, 9'd32, 5'd31, 5'd16);   // dmemout = 0xF
      // Program 2: assemble a 64-bit constant from four halfwords
      6'd14: w = enc_iw(2'd3, 16'h1234, 5'd1);
      6'd15: w = enc_iw(2'd2, 16'h5678, 5'd2);
      6'd16: w = enc_iw(2'd1, 16'h9abc, 5'd3);
      6'd17: w = enc_iw(2'd0, 16'hdef0, 5'd4);
      6'd18: w = enc_r(OP_ORR, 5'd2, 5'd1, 5'd5);
      6'd19: w = enc_r(OP_ORR, 5'd3, 5'd5, 5'd5);
      6'd20: w = enc_r(OP_ORR, 5'd4, 5'd5, 5'd5);
      6'd21: w = enc_d(OP_STUR, 9'd40, 5'd31, 5'd5);    // RAM[5] = result
      6'd22: w = enc_r(OP_ADD, 5'd5, 5'd5, 5'd31);      // write to XZR, discarded
      6'd23: w = enc_d(OP_LDUR, 9'd40, 5'd31, 5'd7);    // dmemout = result
      6'd24: w = enc_b(26'd0);                          // halt loop at 0x60
      // Conditional-branch-on-nonzero probe
      6'd25: w = enc_iw(2'd0, 16'h0001, 5'd20);
      6'd26: w = enc_cb(OP_CBNZ, 19'd4, 5'd20);         // -> 0x78 when supported
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/single_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : single_cycle_ctrl
// Description : Combinational main decoder, instr[31:21] -> control bundle.
//               Optional macro SINGLE_CYCLE_CBNZ_EN enables CBNZ decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module single_cycle_ctrl
  import single_cycle_pkg::*;
(
  input  logic [10:0] opcode_i,
  output ctrl_t       ctrl_o
);

  // Decode the opcode; anything unrecognised leaves all controls low (NOP)
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    if (opcode_i == OP_LDUR) begin
      ctrl_o.alu_src    = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.mem_read   = 1'b1;
    end else if (opcode_i == OP_STUR) begin
      ctrl_o.reg2loc   = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.mem_write = 1'b1;
    end else if (opcode_i == OP_ADD) begin
      ctrl_o.reg_write = 1'b1;
    end else if (opcode_i == OP_SUB) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_SUB;
    end else if (opcode_i == OP_AND) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_AND;
    end else if (opcode_i == OP_ORR) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_ORR;
    end else if (opcode_i[10:2] == OP_MOVZ) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.movz      = 1'b1;
      ctrl_o.alu_op    = ALU_PASSB;
    end else if (opcode_i[10:3] == OP_CBZ) begin
      ctrl_o.reg2loc = 1'b1;
      ctrl_o.branch  = 1'b1;
      ctrl_o.alu_op  = ALU_PASSB;
`ifdef SINGLE_CYCLE_CBNZ_EN
    end else if (opcode_i[10:3] == OP_CBNZ) begin
      ctrl_o.reg2loc   = 1'b1;
      ctrl_o.branch_nz = 1'b1;
      ctrl_o.alu_op    = ALU_PASSB;
`endif
    end else if (opcode_i[10:5] == OP_B) begin
      ctrl_o.uncond = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : single_cycle
// Description : 64-bit single-cycle LEGv8 subset CPU. PC, instruction ROM,
//               32x64 register file (X31 = XZR), ALU and data RAM; one
//               instruction retires per clock.
//               Optional macro SINGLE_CYCLE_CBNZ_EN enables CBNZ.
// Revision    : 1.0 - initial release
// ============================================================================
module single_cycle
  import single_cycle_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] currentpc,
  output logic [63:0] dmemout
);

  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [63:0] pc_q, pc_d;
  logic [63:0] dmem_q, dmem_d;
  logic [63:0] rf_q [31];
  // RAM power-up image; contents survive reset
  logic [63:0] ram_q [DMEM_WORDS] = '{0: 64'h1, 1: 64'hA, 2: 64'h5,
                                      3: 64'h0ffbea7deadbeef, default: 64'h0};

  logic [31:0]     w_instr;
  ctrl_t           w_ctrl;
  logic [4:0]      w_rn, w_rm, w_rd;
  logic [63:0]     w_rdata1, w_rdata2;
  logic [63:0]     w_imm9, w_movz_val, w_cb_off, w_b_off;
  logic [63:0]     w_alu_b, w_alu_y;
  logic            w_zero, w_take;
  logic [DA_W-1:0] w_dm_idx;
  logic [63:0]     w_dm_rdata, w_wb;

  assign currentpc = pc_q;
  assign dmemout   = dmem_q;

  // Fetch: addresses beyond the ROM read as zero, which decodes as a NOP
  assign w_instr = (pc_q[63:2] < 62'(IMEM_WORDS)) ? rom_word(pc_q[7:2]) : 32'h0;

  single_cycle_ctrl u_ctrl (
    .opcode_i (w_instr[31:21]),
    .ctrl_o   (w_ctrl)
  );

  // Register read; STUR/CB* read Rt through the second port
  assign w_rn     = w_instr[9:5];
  assign w_rm     = w_ctrl.reg2loc ? w_instr[4:0] : w_instr[20:16];
  assign w_rd     = w_instr[4:0];
  assign w_rdata1 = (w_rn == 5'd31) ? 64'h0 : rf_q[w_rn];
  assign w_rdata2 = (w_rm == 5'd31) ? 64'h0 : rf_q[w_rm];

  // Immediates
  assign w_imm9     = {{55{w_instr[20]}}, w_instr[20:12]};
  assign w_movz_val = 64'(w_instr[20:5]) << {w_instr[22:21], 4'b0000};
  assign w_cb_off   = {{43{w_instr[23]}}, w_instr[23:5], 2'b00};
  assign w_b_off    = {{36{w_instr[25]}}, w_instr[25:0], 2'b00};

  // ALU: B operand select then operation; PASSB feeds MOVZ and the CB* zero test
  always_comb begin
    w_alu_b = w_rdata2;
    if (w_ctrl.alu_src) begin
      w_alu_b = w_imm9;
    end else if (w_ctrl.movz) begin
      w_alu_b = w_movz_val;
    end
    case (w_ctrl.alu_op)
      ALU_ADD: w_alu_y = w_rdata1 + w_alu_b;
      ALU_SUB: w_alu_y = w_rdata1 - w_alu_b;
      ALU_AND: w_alu_y = w_rdata1 & w_alu_b;
      ALU_ORR: w_alu_y = w_rdata1 | w_alu_b;
      default: w_alu_y = w_alu_b;
    endcase
  end

  assign w_zero = (w_alu_y == 64'h0);
  assign w_take = w_ctrl.uncond | (w_ctrl.branch & w_zero) | (w_ctrl.branch_nz & ~w_zero);

  // Next PC: branch target or sequential
  always_comb begin
    pc_d = pc_q + 64'd4;
    if (w_take) begin
      pc_d = pc_q + (w_ctrl.uncond ? w_b_off : w_cb_off);
    end
  end

  // Data memory read, write-back mux and load capture
  assign w_dm_idx   = w_alu_y[3 +: DA_W];
  assign w_dm_rdata = ram_q[w_dm_idx];
  assign w_wb       = w_ctrl.mem_to_reg ? w_dm_rdata : w_alu_y;
  assign dmem_d     = w_ctrl.mem_read ? w_dm_rdata : dmem_q;

  // Architectural state update: PC, load capture and register file
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      pc_q   <= startpc;
      dmem_q <= 64'h0;
      for (int i = 0; i < 31; i++) begin
        rf_q[i] <= 64'h0;
      end
    end else begin
      pc_q   <= pc_d;
      dmem_q <= dmem_d;
      if (w_ctrl.reg_write && (w_rd != 5'd31)) begin
        rf_q[w_rd] <= w_wb;
      end
    end
  end

  // Data RAM write port; held off during reset so contents persist
  always_ff @(posedge CLK) begin
    if (resetl && w_ctrl.mem_write) begin
      ram_q[w_dm_idx] <= w_rdata2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_cycle
// Description : Self-checking bench for single_cycle. An instruction-level
//               model predicts PC and dmemout each cycle; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_cycle;

`ifdef SINGLE_CYCLE_CBNZ_EN
  localparam bit CBNZ_EN = 1'b1;
`else
  localparam bit CBNZ_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc;
  logic [63:0] currentpc;
  logic [63:0] dmemout;

  single_cycle dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .startpc   (startpc),
    .currentpc (currentpc),
    .dmemout   (dmemout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] dm;
  } exp_t;
  exp_t exp_q[$];

  // Reference machine state
  logic [31:0] m_rom [64];
  logic [63:0] m_x   [32];
  logic [63:0] m_mem [32];
  logic [63:0] m_pc;
  logic [63:0] m_dmem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Encoders, field layout taken from the ISA description
  function automatic logic [31:0] e_r(input logic [10:0] op, input int rm, input int rn, input int rd);
    return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_d(input logic [10:0] op, input int off, input int rn, input int rt);
    return {op, 9'(off), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_mz(input int hw, input logic [15:0] imm, input int rd);
    return {9'b110100101, 2'(hw), imm, 5'(rd)};
  endfunction
  function automatic logic [31:0] e_cb(input logic [7:0] op, input int off, input int rt);
    return {op, 19'(off), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_b(input int off);
    return {6'b000101, 26'(off)};
  endfunction

  function automatic logic [63:0] rx(input int r);
    return (r == 31) ? 64'd0 : m_x[r];
  endfunction

  // Execute one clock edge of the ISA on the model state
  task automatic model_step(input logic rl, input logic [63:0] sp);
    logic [31:0] ins;
    logic [63:0] addr, nxt, res;
    int rd, rn, rm;
    bit wr;
    if (!rl) begin
      m_pc   = sp;
      m_dmem = 64'd0;
      for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
      return;
    end
    ins  = (m_pc / 4 < 64) ? m_rom[m_pc[7:2]] : 32'd0;
    rd   = int'(ins[4:0]);
    rn   = int'(ins[9:5]);
    rm   = int'(ins[20:16]);
    addr = rx(rn) + 64'($signed(ins[20:12]));
    nxt  = m_pc + 64'd4;
    wr   = 1'b0;
    res  = 64'd0;
    if (ins[31:21] == 11'b11111000010) begin
      m_dmem = m_mem[addr[7:3]];
      res = m_dmem; wr = 1'b1;
    end else if (ins[31:21] == 11'b11111000000) begin
      m_mem[addr[7:3]] = rx(rd);
    end else if (ins[31:21] == 11'b10001011000) begin
      res = rx(rn) + rx(rm); wr = 1'b1;
    end else if (ins[31:21] == 11'b11001011000) begin
      res = rx(rn) - rx(rm); wr = 1'b1;
    end else if (ins[31:21] == 11'b10001010000) begin
      res = rx(rn) & rx(rm); wr = 1'b1;
    end else if (ins[31:21] == 11'b10101010000) begin
      res = rx(rn) | rx(rm); wr = 1'b1;
    end else if (ins[31:23] == 9'b110100101) begin
      res = 64'(ins[20:5]) << (16 * int'(ins[22:21])); wr = 1'b1;
    end else if (ins[31:24] == 8'b10110100) begin
      if (rx(rd) == 64'd0) nxt = m_pc + 64'($signed(ins[23:5])) * 64'd4;
    end else if (ins[31:24] == 8'b10110101 && CBNZ_EN) begin
      if (rx(rd) != 64'd0) nxt = m_pc + 64'($signed(ins[23:5])) * 64'd4;
    end else if (ins[31:26] == 6'b000101) begin
      nxt = m_pc + 64'($signed(ins[25:0])) * 64'd4;
    end
    if (wr && rd != 31) m_x[rd] = res;
    m_pc = nxt;
  endtask

  // Drive one cycle (entered just after a falling edge), queue the prediction
  task automatic cycle(input logic rl, input logic [63:0] sp);
    exp_t e;
    resetl  = rl;
    startpc = sp;
    model_step(rl, sp);
    e.pc = m_pc;
    e.dm = m_dmem;
    exp_q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  task automatic run_until(input logic [63:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (currentpc !== target && n < budget) begin
      cycle(1'b1, {$urandom, $urandom});
      n++;
    end
    check(name, currentpc, target);
  endtask

  // Monitor: compare DUT against the oldest prediction on each falling edge
  always @(negedge CLK) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("trace_pc", currentpc, e.pc);
      check("trace_dmemout", dmemout, e.dm);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] held, sp;
    for (int i = 0; i < 64; i++) m_rom[i] = 32'd0;
    m_rom[0]  = e_d(11'b11111000010, 0, 31, 9);
    m_rom[1]  = e_d(11'b11111000010, 8, 31, 10);
    m_rom[2]  = e_d(11'b11111000010, 16, 31, 11);
    m_rom[3]  = e_d(11'b11111000010, 24, 31, 12);
    m_rom[4]  = e_r(11'b10101010000, 11, 10, 13);
    m_rom[5]  = e_r(11'b10001010000, 13, 12, 14);
    m_rom[6]  = e_r(11'b11001011000, 9, 14, 15);
    m_rom[7]  = e_r(11'b10001011000, 9, 15, 15);
    m_rom[8]  = e_cb(8'b10110100, 2, 31);
    m_rom[9]  = e_r(11'b10001011000, 15, 15, 15);
    m_rom[10] = e_cb(8'b10110100, -10, 9);
    m_rom[11] = e_d(11'b11111000000, 32, 31, 15);
    m_rom[12] = e_b(1);
    m_rom[13] = e_d(11'b11111000010, 32, 31, 16);
    m_rom[14] = e_mz(3, 16'h1234, 1);
    m_rom[15] = e_mz(2, 16'h5678, 2);
    m_rom[16] = e_mz(1, 16'h9abc, 3);
    m_rom[17] = e_mz(0, 16'hdef0, 4);
    m_rom[18] = e_r(11'b10101010000, 2, 1, 5);
    m_rom[19] = e_r(11'b10101010000, 3, 5, 5);
    m_rom[20] = e_r(11'b10101010000, 4, 5, 5);
    m_rom[21] = e_d(11'b11111000000, 40, 31, 5);
    m_rom[22] = e_r(11'b10001011000, 5, 5, 31);
    m_rom[23] = e_d(11'b11111000010, 40, 31, 7);
    m_rom[24] = e_b(0);
    m_rom[25] = e_mz(0, 16'h0001, 20);
    m_rom[26] = e_cb(8'b10110101, 4, 20);
    for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
    m_mem[0] = 64'h1;
    m_mem[1] = 64'hA;
    m_mem[2] = 64'h5;
    m_mem[3] = 64'h0ffbea7deadbeef;
    m_pc = 64'd0; m_dmem = 64'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 64'd0;

    resetl  = 1'b0;
    startpc = 64'd0;
    @(negedge CLK);
    #1;

    // Reset state
    cycle(1'b0, 64'd0);
    check("reset_pc", currentpc, 64'd0);
    check("reset_dmemout", dmemout, 64'd0);

    // Program 1
    run_until(64'h34, 60, "reach_0x34");
    cycle(1'b1, 64'd0);
    check("prog1_pc", currentpc, 64'h38);
    check("prog1_dmemout", dmemout, 64'hF);

    // Program 2
    run_until(64'h5c, 60, "reach_0x5c");
    cycle(1'b1, 64'd0);
    check("prog2_pc", currentpc, 64'h60);
    check("prog2_dmemout", dmemout, 64'h123456789abcdef0);

    // Halt loop
    repeat (6) cycle(1'b1, {$urandom, $urandom});
    check("halt_pc", currentpc, 64'h60);
    check("halt_dmemout", dmemout, 64'h123456789abcdef0);

    // Reset into Program 2
    cycle(1'b0, 64'h38);
    check("restart_pc", currentpc, 64'h38);
    check("restart_dmemout", dmemout, 64'd0);
    run_until(64'h5c, 60, "rerun_reach_0x5c");
    cycle(1'b1, 64'd0);
    check("rerun_pc", currentpc, 64'h60);
    check("rerun_dmemout", dmemout, 64'h123456789abcdef0);

    // Outside ROM: zero words are NOPs
    held = dmemout;
    cycle(1'b0, 64'h100);
    repeat (3) cycle(1'b1, 64'd0);
    check("nop_pc", currentpc, 64'h10c);
    check("nop_dmemout", dmemout, 64'd0);

    // CBNZ on a nonzero register
    cycle(1'b0, 64'h64);
    cycle(1'b1, 64'd0);
    cycle(1'b1, 64'd0);
    check("cbnz_pc", currentpc, CBNZ_EN ? 64'h78 : 64'h6c);

    // Random resets, entry points and run lengths
    for (int seg = 0; seg < 25; seg++) begin
      repeat ($urandom_range(1, 2)) begin
        case ($urandom_range(0, 4))
          0: sp = 64'(4 * $urandom_range(0, 63));
          1: sp = 64'h0;
          2: sp = 64'h38;
          3: sp = 64'h64;
          default: sp = 64'h100 + 64'(4 * $urandom_range(0, 63));
        endcase
        cycle(1'b0, sp);
      end
      repeat ($urandom_range(3, 40)) cycle(1'b1, {$urandom, $urandom});
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
